// File: rtl/vfu_mem_scratchpad_if.sv
// Vector and host request/response signals of the Vfu scratchpad.
interface vfu_mem_scratchpad_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int HOST_WIDTH = 32
);
  logic                  vec_rd;
  logic                  vec_wr;
  logic [ADDR_WIDTH-1:0] vec_addr;
  logic [DATA_WIDTH-1:0] vec_wdata;
  logic                  vec_req_ready;
  logic [DATA_WIDTH-1:0] vec_rsp_data;
  logic                  vec_rsp_valid;
  logic                  vec_rsp_ready;
  logic                  host_wr;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [HOST_WIDTH-1:0] host_wdata;
  logic                  host_ready;

  modport master (
    output vec_rd, vec_wr, vec_addr, vec_wdata, vec_rsp_ready,
           host_wr, host_addr, host_wdata,
    input  vec_req_ready, vec_rsp_data, vec_rsp_valid, host_ready
  );

  modport slave (
    input  vec_rd, vec_wr, vec_addr, vec_wdata, vec_rsp_ready,
           host_wr, host_addr, host_wdata,
    output vec_req_ready, vec_rsp_data, vec_rsp_valid, host_ready
  );
endinterface

// File: rtl/vfu_mem_scratchpad.sv
// 64-bit scratchpad behind the vector memory port, with a 2-entry response
// queue and a lower-priority 32-bit host write port.
module vfu_mem_scratchpad #(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int HOST_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  vfu_mem_scratchpad_if.slave  bus,
  output logic [2:0]           err
);
  localparam int IW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Response queue: q0 is the head; cnt doubles as the outstanding-read count.
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] q0_q, q0_d;
  logic [DATA_WIDTH-1:0] q1_q, q1_d;
  logic [2:0]            err_q, err_d;

  logic [IW-1:0]         vidx, hidx;
  logic                  voor, vmis, hoor, hlane;
  logic                  vacc, vwr_acc, vrd_acc, hacc, pop;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_host_lsb;

  assign vidx  = bus.vec_addr[IW+2:3];
  assign voor  = |bus.vec_addr[ADDR_WIDTH-1:IW+3];
  assign vmis  = |bus.vec_addr[2:0];
  assign hidx  = bus.host_addr[IW+2:3];
  assign hoor  = |bus.host_addr[ADDR_WIDTH-1:IW+3];
  assign hlane = bus.host_addr[2];
  assign unused_host_lsb = ^bus.host_addr[1:0];

  assign bus.vec_req_ready = (cnt_q < 2'd2);
  assign vacc    = bus.vec_req_ready & (bus.vec_rd | bus.vec_wr);
  assign vwr_acc = vacc & bus.vec_wr;
  assign vrd_acc = vacc & bus.vec_rd & ~bus.vec_wr;

  // A host write only yields to a vector write that is actually accepted.
  assign bus.host_ready = ~(bus.vec_wr & bus.vec_req_ready);
  assign hacc = bus.host_wr & bus.host_ready;

  assign rd_data = voor ? '0 : mem_q[vidx];

  assign bus.vec_rsp_valid = (cnt_q != 2'd0) & ~reset;
  assign bus.vec_rsp_data  = bus.vec_rsp_valid ? q0_q : '0;
  assign pop = bus.vec_rsp_valid & bus.vec_rsp_ready;
  assign err = err_q;

  // Memory array: vector word writes and per-lane host writes (never both at once).
  always_ff @(posedge clk) begin
    if (vwr_acc && !voor)
      mem_q[vidx] <= bus.vec_wdata;
    if (hacc && !hoor) begin
      if (hlane)
        mem_q[hidx][HOST_WIDTH +: HOST_WIDTH] <= bus.host_wdata;
      else
        mem_q[hidx][0 +: HOST_WIDTH] <= bus.host_wdata;
    end
  end

  // Next-state for the response queue and sticky error flags.
  always_comb begin
    cnt_d = cnt_q;
    q0_d  = q0_q;
    q1_d  = q1_q;
    unique case ({vrd_acc, pop})
      2'b10: begin
        if (cnt_q == 2'd0) q0_d = rd_data;
        else               q1_d = rd_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        q0_d  = q1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          q0_d = rd_data;
        end else begin
          q0_d = q1_q;
          q1_d = rd_data;
        end
      end
      default: ;
    endcase
    err_d = err_q | {vacc & bus.vec_rd & bus.vec_wr,
                     (vacc & voor) | (hacc & hoor),
                     vacc & vmis};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      q0_q  <= '0;
      q1_q  <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      q0_q  <= q0_d;
      q1_q  <= q1_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_vfu_mem_scratchpad.sv
// Directed bench for vfu_mem_scratchpad.
module tb_vfu_mem_scratchpad;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] err;
  int checks = 0;
  int failures = 0;

  vfu_mem_scratchpad_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .HOST_WIDTH(32)) bus ();

  vfu_mem_scratchpad #(.DEPTH(512), .ADDR_WIDTH(32), .DATA_WIDTH(64), .HOST_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.vec_rd = 1'b0; bus.vec_wr = 1'b0; bus.vec_addr = '0; bus.vec_wdata = '0;
    bus.host_wr = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  task automatic vwrite(input logic [31:0] a, input logic [63:0] d);
    bus.vec_wr = 1'b1; bus.vec_addr = a; bus.vec_wdata = d;
    tick();
    bus.vec_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.vec_rsp_ready = 1'b1;
    tick();
    #1;
    chk("rst_valid", {63'd0, bus.vec_rsp_valid}, 64'd0);
    chk("rst_data", bus.vec_rsp_data, 64'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_valid", {63'd0, bus.vec_rsp_valid}, 64'd0);
    chk("post_rst_data", bus.vec_rsp_data, 64'd0);
    chk("post_rst_req_ready", {63'd0, bus.vec_req_ready}, 64'd1);
    chk("post_rst_host_ready", {63'd0, bus.host_ready}, 64'd1);
    chk("post_rst_err", {61'd0, err}, 64'd0);

    // Vector write then read
    bus.vec_wr = 1'b1; bus.vec_addr = 32'h40; bus.vec_wdata = 64'h1122334455667788;
    #1;
    chk("wr_host_ready_blocked", {63'd0, bus.host_ready}, 64'd0);
    tick();
    bus.vec_wr = 1'b0; bus.vec_rd = 1'b1;
    #1;
    chk("wr_rd_valid_early", {63'd0, bus.vec_rsp_valid}, 64'd0);
    tick();
    bus.vec_rd = 1'b0;
    chk("wr_rd_valid", {63'd0, bus.vec_rsp_valid}, 64'd1);
    chk("wr_rd_data", bus.vec_rsp_data, 64'h1122334455667788);
    chk("wr_rd_err", {61'd0, err}, 64'd0);
    tick();
    chk("wr_rd_drained", {63'd0, bus.vec_rsp_valid}, 64'd0);

    // Backpressure
    vwrite(32'h00, 64'hA0A0_0000_0000_00A0);
    vwrite(32'h08, 64'hA1A1_0000_0000_00A1);
    vwrite(32'h10, 64'hA2A2_0000_0000_00A2);
    bus.vec_rsp_ready = 1'b0;
    bus.vec_rd = 1'b1; bus.vec_addr = 32'h00;
    #1;
    chk("bp_ready0", {63'd0, bus.vec_req_ready}, 64'd1);
    tick();
    bus.vec_addr = 32'h08;
    chk("bp_ready1", {63'd0, bus.vec_req_ready}, 64'd1);
    chk("bp_head1", bus.vec_rsp_data, 64'hA0A0_0000_0000_00A0);
    tick();
    bus.vec_addr = 32'h10;
    chk("bp_ready2", {63'd0, bus.vec_req_ready}, 64'd0);
    chk("bp_head2", bus.vec_rsp_data, 64'hA0A0_0000_0000_00A0);
    tick();
    chk("bp_ready_held", {63'd0, bus.vec_req_ready}, 64'd0);
    chk("bp_head_held", bus.vec_rsp_data, 64'hA0A0_0000_0000_00A0);
    chk("bp_valid_held", {63'd0, bus.vec_rsp_valid}, 64'd1);
    bus.vec_rsp_ready = 1'b1;
    tick();
    chk("bp_pop1_data", bus.vec_rsp_data, 64'hA1A1_0000_0000_00A1);
    chk("bp_third_accept_ready", {63'd0, bus.vec_req_ready}, 64'd1);
    tick();
    bus.vec_rd = 1'b0;
    chk("bp_pop2_data", bus.vec_rsp_data, 64'hA2A2_0000_0000_00A2);
    chk("bp_pop2_valid", {63'd0, bus.vec_rsp_valid}, 64'd1);
    tick();
    chk("bp_drained", {63'd0, bus.vec_rsp_valid}, 64'd0);

    // Streaming
    for (int i = 0; i < 16; i++)
      vwrite(32'h100 + 32'(i) * 8, 64'h0100_0000_0000_0000 + 64'(i) * 64'h0001_0001);
    for (int i = 0; i < 16; i++) begin
      bus.vec_rd = 1'b1; bus.vec_addr = 32'h100 + 32'(i) * 8;
      #1;
      chk($sformatf("st_ready%0d", i), {63'd0, bus.vec_req_ready}, 64'd1);
      if (i > 0)
        chk($sformatf("st_data%0d", i - 1), bus.vec_rsp_data,
            64'h0100_0000_0000_0000 + 64'(i - 1) * 64'h0001_0001);
      tick();
    end
    bus.vec_rd = 1'b0;
    chk("st_data15", bus.vec_rsp_data, 64'h0100_0000_0000_0000 + 64'd15 * 64'h0001_0001);
    tick();
    chk("st_drained", {63'd0, bus.vec_rsp_valid}, 64'd0);

    // Host lanes
    bus.host_wr = 1'b1; bus.host_addr = 32'h44; bus.host_wdata = 32'hDEADBEEF;
    #1;
    chk("host_ready_free", {63'd0, bus.host_ready}, 64'd1);
    tick();
    bus.host_addr = 32'h40; bus.host_wdata = 32'hCAFEF00D;
    tick();
    bus.host_wr = 1'b0;
    bus.vec_rd = 1'b1; bus.vec_addr = 32'h40;
    tick();
    bus.vec_rd = 1'b0;
    chk("host_lanes", bus.vec_rsp_data, 64'hDEADBEEFCAFEF00D);
    tick();

    // Host priority: collision, then retry
    vwrite(32'h80, 64'd0);
    bus.vec_wr = 1'b1; bus.vec_addr = 32'h48; bus.vec_wdata = 64'h0123456789ABCDEF;
    bus.host_wr = 1'b1; bus.host_addr = 32'h80; bus.host_wdata = 32'h13579BDF;
    #1;
    chk("host_collide_ready", {63'd0, bus.host_ready}, 64'd0);
    tick();
    bus.vec_wr = 1'b0; bus.host_wr = 1'b0;
    bus.vec_rd = 1'b1; bus.vec_addr = 32'h80;
    tick();
    bus.vec_addr = 32'h48;
    chk("host_not_landed", bus.vec_rsp_data, 64'd0);
    tick();
    bus.vec_rd = 1'b0;
    chk("vec_won_collision", bus.vec_rsp_data, 64'h0123456789ABCDEF);
    bus.host_wr = 1'b1;
    #1;
    chk("host_retry_ready", {63'd0, bus.host_ready}, 64'd1);
    tick();
    bus.host_wr = 1'b0;
    bus.vec_rd = 1'b1; bus.vec_addr = 32'h80;
    tick();
    bus.vec_rd = 1'b0;
    chk("host_retry_landed", bus.vec_rsp_data, 64'h0000_0000_1357_9BDF);
    // same-cycle host write and vector read of one word
    bus.host_wr = 1'b1; bus.host_addr = 32'h84; bus.host_wdata = 32'h2468ACE0;
    bus.vec_rd = 1'b1; bus.vec_addr = 32'h80;
    tick();
    bus.host_wr = 1'b0;
    chk("host_same_cycle_old", bus.vec_rsp_data, 64'h0000_0000_1357_9BDF);
    tick();
    bus.vec_rd = 1'b0;
    chk("host_same_cycle_new", bus.vec_rsp_data, 64'h2468_ACE0_1357_9BDF);
    tick();

    // Errors
    chk("err_clear", {61'd0, err}, 64'd0);
    vwrite(32'h43, 64'h77);
    chk("err_misaligned", {61'd0, err}, 64'd1);
    bus.vec_rd = 1'b1; bus.vec_addr = 32'h1000;
    tick();
    bus.vec_rd = 1'b0;
    chk("oor_valid", {63'd0, bus.vec_rsp_valid}, 64'd1);
    chk("oor_data", bus.vec_rsp_data, 64'd0);
    chk("err_oor", {61'd0, err}, 64'd3);
    tick();
    bus.vec_rd = 1'b1; bus.vec_wr = 1'b1; bus.vec_addr = 32'h50; bus.vec_wdata = 64'hABCD;
    tick();
    bus.vec_rd = 1'b0; bus.vec_wr = 1'b0;
    chk("both_no_rsp", {63'd0, bus.vec_rsp_valid}, 64'd0);
    chk("err_both", {61'd0, err}, 64'd7);
    bus.vec_rd = 1'b1; bus.vec_addr = 32'h50;
    tick();
    bus.vec_addr = 32'h40;
    chk("both_wrote", bus.vec_rsp_data, 64'hABCD);
    tick();
    bus.vec_rd = 1'b0;
    chk("misaligned_wrote", bus.vec_rsp_data, 64'h77);
    tick();
    tick();
    chk("err_sticky", {61'd0, err}, 64'd7);

    // Reset mid-flight
    bus.vec_rsp_ready = 1'b0;
    bus.vec_rd = 1'b1; bus.vec_addr = 32'h00;
    tick();
    bus.vec_addr = 32'h08;
    tick();
    bus.vec_rd = 1'b0;
    chk("mf_full", {63'd0, bus.vec_req_ready}, 64'd0);
    reset = 1'b1;
    #1;
    chk("mf_rst_valid", {63'd0, bus.vec_rsp_valid}, 64'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("mf_valid", {63'd0, bus.vec_rsp_valid}, 64'd0);
    chk("mf_data", bus.vec_rsp_data, 64'd0);
    chk("mf_err", {61'd0, err}, 64'd0);
    chk("mf_ready", {63'd0, bus.vec_req_ready}, 64'd1);
    bus.vec_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mf_no_stale%0d", i), {63'd0, bus.vec_rsp_valid}, 64'd0);
    end
    bus.vec_rd = 1'b1; bus.vec_addr = 32'h08;
    tick();
    bus.vec_rd = 1'b0;
    chk("mf_resume", bus.vec_rsp_data, 64'hA1A1_0000_0000_00A1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vfu_mem_scratchpad.md
Name: vfu_mem_scratchpad

Overview:
- Local 64-bit scratchpad memory that services the vector processor's memory port inside the Vfu.
- Sits directly downstream of rvv_proc_main's mem_port_* signals:
  - accepts vector load/store requests;
  - returns load data through a 2-entry response queue with backpressure.
- A secondary 32-bit host port lets the CPU preload or inspect memory at lower priority.

Parameters:
- DEPTH, 512, number of 64-bit words; power of two.
- ADDR_WIDTH, 32, width of byte addresses on both ports.
- DATA_WIDTH, 64, vector-side word width; fixed at 64.
- HOST_WIDTH, 32, host-side data width; fixed at 32.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- vec_rd  in  1  vector read request (driven by mem_port_req)
- vec_wr  in  1  vector write request (driven by mem_port_valid_out)
- vec_addr  in  ADDR_WIDTH  byte address of the request
- vec_wdata  in  DATA_WIDTH  write data
- vec_req_ready  out  1  request accepted this cycle when high
- vec_rsp_data  out  DATA_WIDTH  read data (feeds mem_port_in)
- vec_rsp_valid  out  1  vec_rsp_data is valid
- vec_rsp_ready  in  1  consumer accepts the response (driven by mem_port_ready_out)
- host_wr  in  1  host 32-bit write request
- host_addr  in  ADDR_WIDTH  host byte address
- host_wdata  in  HOST_WIDTH  host write data
- host_ready  out  1  host write accepted this cycle
- err  out  3  sticky flags: [0] misaligned vector address, [1] out-of-range address (either port), [2] vec_rd and vec_wr both high

Behaviour:
- Reset: synchronous, active-high.
  - Clears the outstanding counter, the response queue and err.
  - vec_rsp_valid=0 and vec_rsp_data=0 during reset and in the cycle after.
  - vec_req_ready=1 and host_ready=1 in the first cycle after reset deasserts.
  - Memory contents are not reset.
  - Reset mid-operation discards queued and in-flight reads; no response emerges afterwards.
- Addressing:
  - Vector word index = vec_addr[3+log2(DEPTH)-1:3].
  - vec_addr[2:0] != 0 sets err[0]; the access proceeds with the low bits ignored.
  - Any address bit above the index range set makes the access out of range: writes are dropped, reads return 0, err[1] set.
  - Host: same word index from host_addr; host_addr[2] selects lane (0 = bits 31:0, 1 = bits 63:32); host_addr[1:0] ignored.
- Outstanding counter (0..2): counts reads accepted but not yet handshaken on the response side.
  - vec_req_ready = (outstanding < 2). Combinational from registered state only; no dependence on vec_rd/vec_wr.
  - Writes also require vec_req_ready, so request ordering is preserved.
- Request accepted at edge t when vec_req_ready and (vec_rd or vec_wr).
  - Write: the memory holds vec_wdata from t+1. A read accepted at t+1 to the same word returns the new data.
  - Read: the SRAM is read synchronously and the result enters the response queue; vec_rsp_valid is high from t+1.
- vec_rd and vec_wr high together: treated as a write, the read is dropped, err[2] set.
- Response queue:
  - 2-entry FIFO; the head drives vec_rsp_data.
  - An entry pops when vec_rsp_valid and vec_rsp_ready.
  - Data is held stable while vec_rsp_valid and !vec_rsp_ready.
- Accept and pop in the same cycle leaves outstanding unchanged.
- With vec_rsp_ready tied high, throughput is 1 read per cycle and latency is 1 cycle.
- Host arbitration:
  - host_ready = !(vec_wr & vec_req_ready) — a host write yields to an accepted vector write.
  - An accepted host write is a read-modify-write of one 32-bit lane and leaves the other lane unchanged. It is performed with a per-lane write enable, not an extra cycle.
  - Vector reads do not block host writes; a same-cycle vector read of that word returns the pre-write data.
- err bits stay set until reset.

Test Plan:
- Vector write then read:
  - Stimulus: write 0x1122334455667788 to addr 0x40; next cycle read 0x40 with vec_rsp_ready=1.
  - Response: vec_rsp_valid one cycle after the read is accepted, data 0x1122334455667788, err=0.
- Backpressure:
  - Stimulus: vec_rsp_ready=0; reads of 0x00, 0x08, 0x10 on consecutive cycles.
  - Response: first two accepted; vec_req_ready=0 on the third; head data held stable.
  - Then raise vec_rsp_ready: responses arrive in order, and the third read is accepted the cycle after the first pop.
- Streaming:
  - Stimulus: 16 back-to-back reads with vec_rsp_ready=1.
  - Response: vec_req_ready never drops; 16 responses on consecutive cycles, in address order.
- Host lanes and priority:
  - Stimulus: host writes 0xDEADBEEF to 0x44 and 0xCAFEF00D to 0x40; then a vector read of 0x40.
  - Response: data 0xDEADBEEFCAFEF00D.
  - Also: a host write coinciding with a vector write gives host_ready=0, and the host write lands only when retried.
- Errors:
  - vec_addr=0x43 sets err[0].
  - Address DEPTH*8 returns a read of 0 and sets err[1].
  - vec_rd=vec_wr=1 writes and sets err[2].
  - All three flags persist until reset.
- Reset mid-flight:
  - Stimulus: two reads outstanding with vec_rsp_ready=0, then assert reset for 1 cycle.
  - Response: vec_rsp_valid=0 and err=0 afterwards; vec_req_ready=1; no stale response ever appears.
